regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the decode stage. Successor to the single-write, two-read, fixed 8x16 file.
- Width, depth and read-port count are configurable. Provides two write ports with fixed priority and same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers. Optionally hardwires register 0 to zero.

Parameters:
- W, 16, data width in bits
- N, 3, address width in bits; depth = 2**N
- NRD, 2, number of read ports (at least 1)
- ZERO_REG, 0, when 1, register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  2  write enable per write port; bit 1 is port 1
- wr_addr  in  2*N  write addresses; port p occupies bits [p*N +: N]
- wr_data  in  2*W  write data; port p occupies bits [p*W +: W]
- rd_addr  in  NRD*N  read addresses; port r occupies bits [r*N +: N]
- rd_data  out  NRD*W  read data, combinational, includes bypass
- rd_busy  out  NRD  busy status of the addressed register, after same-cycle clears
- sb_set  in  1  mark sb_addr busy (decode issued a producer)
- sb_addr  in  N  register to mark busy

Behaviour:
- Reset, asserted asynchronously while rst=0:
  - all registers clear to 0 and all busy bits clear to 0
  - rd_data = 0 and rd_busy = 0 on every port
  - bypass and sb_set are ignored while rst=0
- Write:
  - on the rising edge, if wr_en[p] is set, reg[wr_addr_p] <= wr_data_p
  - both ports writing the same address: port 1 wins
- Read:
  - rd_data_r is combinational with zero latency
  - priority: port-1 write to the same address, then port-0 write, then the stored value
  - this gives write-first semantics in the same cycle; it replaces the old negedge-write scheme, and all state now uses the rising edge only
- Scoreboard:
  - on the rising edge, any enabled write clears the busy bit of its address
  - sb_set sets busy[sb_addr]
  - set and clear on the same address in the same cycle: set wins (a new producer overrides the retiring one)
- rd_busy_r = busy[rd_addr_r], forced to 0 if an enabled write targets rd_addr_r this cycle and sb_set is not targeting that address.
- ZERO_REG=1:
  - writes to address 0 are dropped
  - sb_set to address 0 is dropped
  - rd_data for address 0 is 0 even when bypass matches; rd_busy for address 0 is 0
- Reset mid-operation: state clears immediately; writes pending in that cycle are lost.
- No X propagation: out-of-range addresses cannot occur, because depth is exactly 2**N.

Decomposition:
- Package regfile_pkg holds:
  - default W, N and NRD
  - localparam DEPTH = 2**N
  - helper functions for flattened-bus slicing
- Sub-module rf_read_port: one instance per read port.
  - Takes the storage array, busy vector, both write ports, sb_set/sb_addr and one rd_addr.
  - Produces one rd_data and one rd_busy.
  - Holds all bypass and priority logic.
- The top level holds storage, the write decoder and the scoreboard flops.

Test Plan:
- Reset: write 0xBEEF to r3, then pull rst low asynchronously between edges -> rd_data for r3 reads 0x0000 immediately, and all rd_busy bits are 0.
- Bypass: in the same cycle, wr_en=01, addr0=5, data0=0x1234, rd_addr port0=5 -> rd_data0=0x1234 before the edge; after the edge, reads of r5 return 0x1234.
- Dual-write conflict: both ports write r2, port0=0x1111, port1=0x2222 -> same-cycle read returns 0x2222 and r2 holds 0x2222 afterwards.
- Scoreboard:
  - sb_set r4 -> rd_busy=1 for r4 on the next cycle
  - write r4 with sb_set=0 -> rd_busy=0 in the write cycle and stays 0 afterwards
  - write r4 with sb_set r4 in the same cycle -> rd_busy stays 1
- ZERO_REG=1: write 0xFFFF to r0 and sb_set r0 -> rd_data=0 and rd_busy=0 both in-cycle and afterwards.
- NRD=4, W=32, N=5: four ports read r0, r7, r31 and r7 while r31 is written with 0xCAFEF00D -> r31 bypasses correctly, and the duplicate r7 ports return identical data.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and flattened-bus slicing helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned W_DEF   = 16;
    localparam int unsigned N_DEF   = 3;
    localparam int unsigned NRD_DEF = 2;
    localparam int unsigned DEPTH   = 2 ** N_DEF;

    // Low bit index of field idx in a bus of width-wide fields.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: write-first bypass, zero-register masking and busy lookup with same-cycle clear.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned N        = N_DEF,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic             i_rst_n,
    input  logic [W-1:0]     i_mem [2**N],
    input  logic [2**N-1:0]  i_busy,
    input  logic [1:0]       i_wr_en,
    input  logic [2*N-1:0]   i_wr_addr,
    input  logic [2*W-1:0]   i_wr_data,
    input  logic             i_sb_set,
    input  logic [N-1:0]     i_sb_addr,
    input  logic [N-1:0]     i_rd_addr,
    output logic [W-1:0]     o_rd_data_c,
    output logic             o_rd_busy_c
);

    logic [N-1:0] w_wa0;
    logic [N-1:0] w_wa1;
    logic [W-1:0] w_wd0;
    logic [W-1:0] w_wd1;
    logic         w_hit0;
    logic         w_hit1;
    logic         w_zero;
    logic         w_set_here;

    assign w_wa0      = i_wr_addr[slice_lo(0, N) +: N];
    assign w_wa1      = i_wr_addr[slice_lo(1, N) +: N];
    assign w_wd0      = i_wr_data[slice_lo(0, W) +: W];
    assign w_wd1      = i_wr_data[slice_lo(1, W) +: W];
    assign w_hit0     = i_wr_en[0] && (w_wa0 == i_rd_addr);
    assign w_hit1     = i_wr_en[1] && (w_wa1 == i_rd_addr);
    assign w_zero     = (ZERO_REG != 0) && (i_rd_addr == '0);
    assign w_set_here = i_sb_set && (i_sb_addr == i_rd_addr);

    // Port 1 write beats port 0 write beats storage; a retiring write hides busy unless re-issued.
    always_comb begin
        o_rd_data_c = '0;
        o_rd_busy_c = 1'b0;
        if (i_rst_n && !w_zero) begin
            if (w_hit1) begin
                o_rd_data_c = w_wd1;
            end else if (w_hit0) begin
                o_rd_data_c = w_wd0;
            end else begin
                o_rd_data_c = i_mem[i_rd_addr];
            end
            o_rd_busy_c = i_busy[i_rd_addr] && !((w_hit0 || w_hit1) && !w_set_here);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised 2-write / NRD-read register file with bypass and RAW busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned W        = W_DEF,
    parameter int unsigned N        = N_DEF,
    parameter int unsigned NRD      = NRD_DEF,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wr_en,
    input  logic [2*N-1:0]   wr_addr,
    input  logic [2*W-1:0]   wr_data,
    input  logic [NRD*N-1:0] rd_addr,
    output logic [NRD*W-1:0] rd_data,
    output logic [NRD-1:0]   rd_busy,
    input  logic             sb_set,
    input  logic [N-1:0]     sb_addr
);

    localparam int unsigned D = 2 ** N;

    logic [W-1:0] r_mem [D];
    logic [D-1:0] r_busy;

    logic [N-1:0] w_wa0;
    logic [N-1:0] w_wa1;
    logic [W-1:0] w_wd0;
    logic [W-1:0] w_wd1;
    logic         w_we0;
    logic         w_we1;
    logic         w_sb_set;

    assign w_wa0    = wr_addr[slice_lo(0, N) +: N];
    assign w_wa1    = wr_addr[slice_lo(1, N) +: N];
    assign w_wd0    = wr_data[slice_lo(0, W) +: W];
    assign w_wd1    = wr_data[slice_lo(1, W) +: W];
    assign w_we0    = wr_en[0] && !((ZERO_REG != 0) && (w_wa0 == '0));
    assign w_we1    = wr_en[1] && !((ZERO_REG != 0) && (w_wa1 == '0));
    assign w_sb_set = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));

    // Storage: port 1 is applied last so it wins an address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(D); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_mem[w_wa0] <= w_wd0;
            end
            if (w_we1) begin
                r_mem[w_wa1] <= w_wd1;
            end
        end
    end

    // Scoreboard: writes retire producers, a new issue to the same register overrides the retire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            if (wr_en[0]) begin
                r_busy[w_wa0] <= 1'b0;
            end
            if (wr_en[1]) begin
                r_busy[w_wa1] <= 1'b0;
            end
            if (w_sb_set) begin
                r_busy[sb_addr] <= 1'b1;
            end
        end
    end

    // One bypassing read port per requested read.
    for (genvar r = 0; r < int'(NRD); r++) begin : g_rd
        rf_read_port #(
            .W        (W),
            .N        (N),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .i_rst_n     (rst),
            .i_mem       (r_mem),
            .i_busy      (r_busy),
            .i_wr_en     (wr_en),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data),
            .i_sb_set    (sb_set),
            .i_sb_addr   (sb_addr),
            .i_rd_addr   (rd_addr[r*N +: N]),
            .o_rd_data_c (rd_data[r*W +: W]),
            .o_rd_busy_c (rd_busy[r])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default file (table), zero-register file and wide 4-read-port file.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;

    // Instance A: W=16 N=3 NRD=2 ZERO_REG=0
    logic [1:0]  a_wr_en;
    logic [5:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [5:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_sb_set;
    logic [2:0]  a_sb_addr;

    // Instance B: W=16 N=3 NRD=2 ZERO_REG=1
    logic [1:0]  b_wr_en;
    logic [5:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [5:0]  b_rd_addr;
    logic [31:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic        b_sb_set;
    logic [2:0]  b_sb_addr;

    // Instance C: W=32 N=5 NRD=4 ZERO_REG=0
    logic [1:0]   c_wr_en;
    logic [9:0]   c_wr_addr;
    logic [63:0]  c_wr_data;
    logic [19:0]  c_rd_addr;
    logic [127:0] c_rd_data;
    logic [3:0]   c_rd_busy;
    logic         c_sb_set;
    logic [4:0]   c_sb_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.W(16), .N(3), .NRD(2), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .sb_set(a_sb_set), .sb_addr(a_sb_addr)
    );

    regfile_mp #(.W(16), .N(3), .NRD(2), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .sb_set(b_sb_set), .sb_addr(b_sb_addr)
    );

    regfile_mp #(.W(32), .N(5), .NRD(4), .ZERO_REG(0)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .sb_set(c_sb_set), .sb_addr(c_sb_addr)
    );

    typedef struct {
        logic [1:0]  wr_en;
        logic [2:0]  wa0;
        logic [15:0] wd0;
        logic [2:0]  wa1;
        logic [15:0] wd1;
        logic        sb_set;
        logic [2:0]  sb_addr;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [15:0] exp_d0;
        logic [15:0] exp_d1;
        logic [1:0]  exp_busy;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_sb_set = 1'b0; a_sb_addr = '0;
        b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_sb_set = 1'b0; b_sb_addr = '0;
        c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_sb_set = 1'b0; c_sb_addr = '0;
    endtask

    initial begin
        //           wr_en  wa0   wd0        wa1   wd1        sb    sba   ra0   ra1   exp_d0     exp_d1     busy
        vecs[0]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd5, 16'h0000, 16'h0000, 2'b00};
        vecs[1]  = '{2'b01, 3'd5, 16'h1234, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd3, 16'h1234, 16'h0000, 2'b00};
        vecs[2]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd2, 16'h1234, 16'h0000, 2'b00};
        vecs[3]  = '{2'b11, 3'd2, 16'h1111, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd2, 3'd5, 16'h2222, 16'h1234, 2'b00};
        vecs[4]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5, 16'h2222, 16'h1234, 2'b00};
        vecs[5]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd2, 16'h0000, 16'h2222, 2'b00};
        vecs[6]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4, 16'h0000, 16'h0000, 2'b11};
        vecs[7]  = '{2'b10, 3'd0, 16'h0000, 3'd4, 16'h00AA, 1'b0, 3'd0, 3'd4, 3'd2, 16'h00AA, 16'h2222, 2'b00};
        vecs[8]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4, 16'h00AA, 16'h00AA, 2'b00};
        vecs[9]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd2, 16'h00AA, 16'h2222, 2'b00};
        vecs[10] = '{2'b01, 3'd4, 16'h00BB, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd4, 16'h00BB, 16'h00BB, 2'b11};
        vecs[11] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4, 16'h00BB, 16'h00BB, 2'b11};
        vecs[12] = '{2'b01, 3'd4, 16'h00CC, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd4, 3'd6, 16'h00CC, 16'h0000, 2'b00};
        vecs[13] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd6, 16'h00CC, 16'h0000, 2'b10};
        vecs[14] = '{2'b11, 3'd1, 16'h0101, 3'd7, 16'h0707, 1'b0, 3'd0, 3'd1, 3'd7, 16'h0101, 16'h0707, 2'b00};
        vecs[15] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd7, 16'h0101, 16'h0707, 2'b00};

        // Reset state
        rst = 1'b0;
        idle_all();
        a_rd_addr = {3'd5, 3'd3};
        b_rd_addr = '0;
        c_rd_addr = '0;
        #3;
        chk("reset_a_data", a_rd_data, 32'h0);
        chk("reset_a_busy", 32'(a_rd_busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven sequence on instance A
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            a_wr_en   = vecs[i].wr_en;
            a_wr_addr = {vecs[i].wa1, vecs[i].wa0};
            a_wr_data = {vecs[i].wd1, vecs[i].wd0};
            a_sb_set  = vecs[i].sb_set;
            a_sb_addr = vecs[i].sb_addr;
            a_rd_addr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_d0", i), 32'(a_rd_data[15:0]), 32'(vecs[i].exp_d0));
            chk($sformatf("vec%0d_d1", i), 32'(a_rd_data[31:16]), 32'(vecs[i].exp_d1));
            chk($sformatf("vec%0d_busy", i), 32'(a_rd_busy), 32'(vecs[i].exp_busy));
        end

        // Zero register: writes and busy-set on r0 are dropped, r1 still works
        @(negedge clk);
        idle_all();
        b_wr_en = 2'b11; b_wr_addr = {3'd0, 3'd0}; b_wr_data = {16'hFFFF, 16'hFFFF};
        b_sb_set = 1'b1; b_sb_addr = 3'd0; b_rd_addr = {3'd0, 3'd0};
        #1;
        chk("zr_incycle_data", b_rd_data, 32'h0);
        chk("zr_incycle_busy", 32'(b_rd_busy), 32'h0);
        @(negedge clk);
        idle_all();
        b_wr_en = 2'b01; b_wr_addr = {3'd0, 3'd1}; b_wr_data = {16'h0000, 16'h4321};
        b_rd_addr = {3'd1, 3'd0};
        #1;
        chk("zr_after_data", b_rd_data, {16'h4321, 16'h0000});
        chk("zr_after_busy", 32'(b_rd_busy), 32'h0);
        @(negedge clk);
        idle_all();
        #1;
        chk("zr_stored_data", b_rd_data, {16'h4321, 16'h0000});
        chk("zr_stored_busy", 32'(b_rd_busy), 32'h0);

        // Wide file with four read ports, duplicate r7 readers, r31 bypass
        @(negedge clk);
        idle_all();
        c_wr_en = 2'b01; c_wr_addr = {5'd0, 5'd7}; c_wr_data = {32'h0, 32'h7777_7777};
        @(negedge clk);
        idle_all();
        c_wr_en = 2'b10; c_wr_addr = {5'd31, 5'd0}; c_wr_data = {32'hCAFE_F00D, 32'h0};
        c_rd_addr = {5'd7, 5'd31, 5'd7, 5'd0};
        #1;
        chk("wide_byp_p0", c_rd_data[31:0],   32'h0);
        chk("wide_byp_p1", c_rd_data[63:32],  32'h7777_7777);
        chk("wide_byp_p2", c_rd_data[95:64],  32'hCAFE_F00D);
        chk("wide_byp_p3", c_rd_data[127:96], 32'h7777_7777);
        chk("wide_byp_busy", 32'(c_rd_busy), 32'h0);
        @(negedge clk);
        idle_all();
        #1;
        chk("wide_st_p0", c_rd_data[31:0],   32'h0);
        chk("wide_st_p1", c_rd_data[63:32],  32'h7777_7777);
        chk("wide_st_p2", c_rd_data[95:64],  32'hCAFE_F00D);
        chk("wide_st_p3", c_rd_data[127:96], 32'h7777_7777);

        // Asynchronous reset between edges clears state and masks bypass
        @(negedge clk);
        idle_all();
        a_wr_en = 2'b01; a_wr_addr = {3'd0, 3'd3}; a_wr_data = {16'h0, 16'hBEEF};
        @(negedge clk);
        idle_all();
        a_rd_addr = {3'd6, 3'd3};
        #1;
        chk("pre_rst_r3", 32'(a_rd_data[15:0]), 32'h0000_BEEF);
        chk("pre_rst_busy_r6", 32'(a_rd_busy), 32'h2);
        #1;
        rst = 1'b0;
        a_wr_en = 2'b01; a_wr_addr = {3'd0, 3'd3}; a_wr_data = {16'h0, 16'h5555};
        a_sb_set = 1'b1; a_sb_addr = 3'd3;
        #1;
        chk("in_rst_data", a_rd_data, 32'h0);
        chk("in_rst_busy", 32'(a_rd_busy), 32'h0);
        chk("in_rst_b_data", b_rd_data, 32'h0);
        chk("in_rst_c_p2", c_rd_data[95:64], 32'h0);
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        #1;
        chk("post_rst_data", a_rd_data, 32'h0);
        chk("post_rst_busy", 32'(a_rd_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
